text_console_buffer: RTL and testbench
======================================

// Module: text_console_buffer
// PURPOSE
//  Character frame buffer sitting directly upstream of the RGB/font stage of the VGA controller.
//  Write side accepts an 8-bit character stream (UART/keyboard) via valid/ready, keeps a cursor, handles control codes.
//  Read side maps the hvsync_generator pixel coordinates to a character cell and returns the stored code as
//  character_select for the font ROM (8x16 glyph cells, 640x480 visible => 80x30 cells).
// PARAMETERS
//  COLS    80  text columns per row (cell width 8 px, col = pix_x>>3)
//  ROWS    30  text rows (cell height 16 px, row = pix_y>>4)
//  CHAR_W  8   width of stored code / character_select
//  BLANK   8'h20  code written by clear and backspace, returned outside the text area
// PORTS
//  clk               in   1       system clock, same clock as the hvsync_generator
//  rst               in   1       asynchronous reset, active high
//  wr_data           in   8       incoming character or control code
//  wr_valid          in   1       wr_data valid
//  wr_ready          out  1       buffer can accept; a transfer occurs when wr_valid & wr_ready at the rising edge of clk
//  pix_x             in   11      current pixel column (CounterX)
//  pix_y             in   11      current pixel row (CounterY)
//  character_select  out  CHAR_W  code of the cell under (pix_x,pix_y), 1-cycle latency
//  cell_active       out  1       1 when that cell lies inside COLS x ROWS, aligned with character_select
//  cursor_col        out  7       current cursor column, 0..COLS-1
//  cursor_row        out  5       current cursor row, 0..ROWS-1
//  busy              out  1       clear sweep in progress
// BEHAVIOUR
//  Storage: COLS*ROWS x CHAR_W RAM, address = row*COLS+col. Contents are not reset; they are initialised by the clear sweep.
//  FSM states: CLEAR, IDLE.
//   - Reset (async) -> CLEAR, sweep ptr=0, cursor=(0,0), wr_ready=0, busy=1, character_select=BLANK, cell_active=0.
//   - CLEAR: write BLANK at ptr each cycle, ptr++. At ptr==COLS*ROWS-1 write the last cell, then -> IDLE next cycle.
//     Duration is exactly COLS*ROWS cycles (2400 at defaults). wr_ready=0, busy=1 throughout.
//   - IDLE: wr_ready=1, busy=0. One character is accepted per cycle, with no bubbles.
//  Accepted codes, handled in the acceptance cycle; the cursor update is visible the next cycle:
//   - 0x20..0x7E: write code at cursor, then col++. col==COLS-1 -> col=0, row++. row==ROWS-1 wraps to row 0 (no scroll).
//   - 0x0D (CR): col=0, row unchanged.
//   - 0x0A (LF): col=0, row++ with the same wrap.
//   - 0x08 (BS): col>0 -> col--, then write BLANK at the new position. col==0 -> no effect (no row back-up).
//   - 0x0C (FF): cursor=(0,0), -> CLEAR (full 2400-cycle sweep).
//   - any other code: accepted and discarded, no state change.
//  Read path: registered address from pix_x[10:3], pix_y[10:4]; synchronous RAM read.
//   - character_select and cell_active are valid 1 clk after pix_x/pix_y are presented. The read path is independent of the FSM.
//   - col>=COLS or row>=ROWS -> character_select=BLANK, cell_active=0. No aliasing into RAM.
//   - Same-cycle write and read of the same cell -> read returns the old value (read-first). The new value is visible from the next cycle.
//   - During CLEAR, reads return the mix of old data and BLANK already swept; this is permitted.
//  Reset asserted mid-sweep or mid-write: the write is abandoned and the sweep restarts from ptr=0 after deassertion.
//  wr_data is don't-care when wr_valid=0. wr_valid held with wr_ready=0 is not lost; it transfers in the first IDLE cycle.
// TESTING
//  1 Reset pulse, hold wr_valid=1 -> wr_ready rises exactly 2400 cycles after rst falls; all 2400 cells read 0x20.
//  2 Write 'A'(0x41) at (0,0); pix=(5,9) -> character_select=0x41, cell_active=1 one cycle later; cursor=(1,0).
//  3 Cursor at (79,29), write 'Z' -> cell 2399=0x5A, cursor=(0,0); pix=(639,479) reads 0x5A.
//  4 Write "AB", BS, BS, BS -> cells (0,0),(1,0)=0x20, cursor=(0,0); the third BS has no effect; 0x0A -> cursor=(0,1).
//  5 pix=(640,0) and (0,480) -> character_select=0x20, cell_active=0. FF -> busy=1 for 2400 cycles, then all cells 0x20.
//  6 rst pulse at sweep cycle 1000 with cursor=(10,5) -> cursor=(0,0), sweep restarts, wr_ready low for a full 2400 cycles.

Source files
------------

// File: rtl/text_console_buffer.sv
// Character frame buffer for an 80x30 text console: a valid/ready write side with a cursor and
// control codes, and a pixel-addressed read side feeding the font ROM.
module text_console_buffer #(
  parameter int                COLS   = 80,
  parameter int                ROWS   = 30,
  parameter int                CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [10:0]       pix_x,
  input  logic [10:0]       pix_y,
  output logic [CHAR_W-1:0] character_select,
  output logic              cell_active,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     ptr, ptr_nx;
  logic [6:0]        col, col_nx;
  logic [4:0]        row, row_nx;
  logic [4:0]        row_inc;
  logic [AW-1:0]     cur_addr;

  logic              we;
  logic [AW-1:0]     wa;
  logic [CHAR_W-1:0] wd;

  logic [CHAR_W-1:0] mem [CELLS];
  logic [CHAR_W-1:0] rd_data;
  logic [7:0]        cell_x;
  logic [6:0]        cell_y;
  logic              in_area;
  logic [AW-1:0]     rd_addr;
  logic              unused_pix_bits;

  assign cur_addr = AW'(row) * AW'(COLS) + AW'(col);
  assign row_inc  = (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      col   <= col_nx;
      row   <= row_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    ptr_nx   = ptr;
    col_nx   = col;
    row_nx   = row;
    we       = 1'b0;
    wa       = cur_addr;
    wd       = BLANK;
    case (state)
      CLEAR: begin
        we = 1'b1;
        wa = ptr;
        if (ptr == AW'(CELLS - 1)) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end else begin
          ptr_nx = ptr + AW'(1);
        end
      end
      IDLE: begin
        if (wr_valid) begin
          if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
            we = 1'b1;
            wd = CHAR_W'(wr_data);
            if (col == 7'(COLS - 1)) begin
              col_nx = '0;
              row_nx = row_inc;
            end else begin
              col_nx = col + 7'd1;
            end
          end else begin
            case (wr_data)
              8'h0D: col_nx = '0;
              8'h0A: begin
                col_nx = '0;
                row_nx = row_inc;
              end
              8'h08: begin
                // Backspace never crosses into the previous row.
                if (col != 7'd0) begin
                  col_nx = col - 7'd1;
                  we     = 1'b1;
                  wa     = cur_addr - AW'(1);
                end
              end
              8'h0C: begin
                col_nx   = '0;
                row_nx   = '0;
                state_nx = CLEAR;
                ptr_nx   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  assign wr_ready   = (state == IDLE);
  assign busy       = (state == CLEAR);
  assign cursor_col = col;
  assign cursor_row = row;

  // Read side: cell coordinates straight from the pixel counters; out-of-area cells never touch RAM.
  assign cell_x          = pix_x[10:3];
  assign cell_y          = pix_y[10:4];
  assign in_area         = (int'(cell_x) < COLS) && (int'(cell_y) < ROWS);
  assign rd_addr         = in_area ? AW'(cell_y) * AW'(COLS) + AW'(cell_x) : '0;
  assign unused_pix_bits = ^{pix_x[2:0], pix_y[3:0]};

  // NOTE: the RAM has no reset; its contents are initialised by the clear sweep instead.
  // Read and write in the same block with non-blocking assignments gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cell_active <= 1'b0;
    else     cell_active <= in_area;
  end

  assign character_select = cell_active ? rd_data : BLANK;

endmodule

// File: tb/tb_text_console_buffer.sv
// Self-checking bench for text_console_buffer: directed scenarios plus a random character stream
// compared against a linear-position reference model of the screen.
module tb_text_console_buffer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [7:0]  character_select;
  logic        cell_active;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [CELLS];
  int         m_col;
  int         m_row;

  text_console_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .wr_data          (wr_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .character_select (character_select),
    .cell_active      (cell_active),
    .cursor_col       (cursor_col),
    .cursor_row       (cursor_row),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) m_mem[i] = BLANK;
    m_col = 0;
    m_row = 0;
  endtask

  // Screen model: printable text advances a linear position that wraps over the whole screen.
  task automatic model_apply(input logic [7:0] c);
    int pos;
    if (c >= 8'h20 && c <= 8'h7E) begin
      pos        = m_row * COLS + m_col;
      m_mem[pos] = c;
      pos        = (pos + 1) % CELLS;
      m_row      = pos / COLS;
      m_col      = pos % COLS;
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row * COLS + m_col] = BLANK;
      end
    end else if (c == 8'h0C) begin
      model_clear();
    end
  endtask

  task automatic send(input logic [7:0] c);
    wr_data  = c;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
    model_apply(c);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, 32'(cursor_col), 32'(m_col));
    check({tag, "_row"}, 32'(cursor_row), 32'(m_row));
  endtask

  task automatic read_px(input string tag, input int x, input int y);
    int cx;
    int cy;
    logic [7:0] exp_c;
    logic       exp_a;
    pix_x = 11'(x);
    pix_y = 11'(y);
    tick();
    cx    = x / 8;
    cy    = y / 16;
    exp_a = (cx < COLS) && (cy < ROWS);
    exp_c = exp_a ? m_mem[cy * COLS + cx] : BLANK;
    check({tag, "_char"}, 32'(character_select), 32'(exp_c));
    check({tag, "_act"}, 32'(cell_active), 32'(exp_a));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < CELLS; i++)
      read_px(tag, (i % COLS) * 8 + $urandom_range(0, 7), (i / COLS) * 16 + $urandom_range(0, 15));
  endtask

  // Counts cycles until the buffer accepts again; a sweep must take exactly CELLS cycles.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!wr_ready && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(CELLS));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [7:0] random_code();
    int unsigned r;
    logic [7:0]  c;
    r = $urandom_range(0, 9);
    if (r <= 5)      c = 8'($urandom_range(32'h20, 32'h7E));
    else if (r == 6) c = 8'h0D;
    else if (r == 7) c = 8'h0A;
    else if (r == 8) c = 8'h08;
    else begin
      c = 8'($urandom);
      if ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0D || c == 8'h0A || c == 8'h08 || c == 8'h0C)
        c = 8'h7F;
    end
    return c;
  endfunction

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    pix_x    = '0;
    pix_y    = '0;
    model_clear();

    // Reset state, then the power-up sweep with wr_valid held.
    #3;
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_char", 32'(character_select), 32'(BLANK));
    check("rst_act", 32'(cell_active), 32'd0);
    check_cursor("rst_cursor");
    tick();
    tick();
    rst = 1'b0;
    wait_ready("init_sweep");
    wr_valid = 1'b0;
    check_cursor("after_null");
    read_all("init_blank");

    // 'A' at the home cell.
    send(8'h41);
    check_cursor("a_cursor");
    read_px("a_read", 5, 9);

    // Same-cycle write and read of one cell returns the old value first.
    pix_x    = 11'(m_col * 8 + 3);
    pix_y    = 11'(m_row * 16 + 7);
    wr_data  = 8'h62;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("rf_old", 32'(character_select), 32'(BLANK));
    model_apply(8'h62);
    tick();
    check("rf_new", 32'(character_select), 32'h62);

    // Random character stream.
    for (int i = 0; i < 600; i++) begin
      send(random_code());
      check_cursor("rnd_cursor");
    end
    read_all("rnd_mem");

    // Form feed: full sweep, then out-of-area reads.
    send(8'h0C);
    check("ff_busy", 32'(busy), 32'd1);
    check("ff_ready", 32'(wr_ready), 32'd0);
    check_cursor("ff_cursor");
    wait_ready("ff_sweep");
    read_all("ff_blank");
    read_px("oob_x", 640, 0);
    read_px("oob_y", 0, 480);
    for (int i = 0; i < 8; i++)
      read_px("oob_rnd", $urandom_range(640, 2047), $urandom_range(0, 2047));

    // Backspace sequence.
    send(8'h41);
    send(8'h42);
    send(8'h08);
    send(8'h08);
    check_cursor("bs2_cursor");
    send(8'h08);
    check_cursor("bs3_cursor");
    read_px("bs_c0", 0, 0);
    read_px("bs_c1", 8, 0);
    send(8'h0A);
    check_cursor("lf_cursor");

    // Last cell and cursor wrap to home.
    send(8'h0D);
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32'h21, 32'h7E)));
    check_cursor("corner_cursor");
    send(8'h5A);
    check_cursor("wrap_cursor");
    read_px("corner_read", 639, 479);
    read_px("corner_left", 632, 479);

    // Reset in the middle of a sweep, with a character held waiting.
    for (int i = 0; i < 5; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'($urandom_range(32'h20, 32'h7E)));
    check_cursor("pre_ff_cursor");
    send(8'h0C);
    for (int i = 0; i < 1000; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    wr_data  = 8'h51;
    wr_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("mrst_ready", 32'(wr_ready), 32'd0);
    check("mrst_busy", 32'(busy), 32'd1);
    check("mrst_act", 32'(cell_active), 32'd0);
    check("mrst_char", 32'(character_select), 32'(BLANK));
    model_clear();
    check_cursor("mrst_cursor");
    tick();
    rst = 1'b0;
    wait_ready("rst_sweep");
    tick();
    wr_valid = 1'b0;
    model_apply(8'h51);
    check_cursor("held_cursor");
    read_all("final_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
